uart_rx: RTL and testbench

Asynchronous serial receiver (8N1, LSB first) that turns the board `uart_rx` pin into a byte stream for the SoC peripheral bus. Samples the line at 16x the baud rate in the CPU clock domain, validates start/stop bits, and buffers received bytes in a small first-word-fall-through FIFO with a valid/ready handshake. It is the receive-side counterpart of the SoC's UART transmitter and is instantiated inside `soc` next to it.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo.sv | 68 ++++++
 rtl/uart_rx.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the SoC UART receiver and transmitter: frame
// geometry and the receive state encoding.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through byte FIFO. The head entry is always visible
// on head_data while the FIFO is non-empty. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle; otherwise it is
// silently ignored and the caller reports the loss.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra pointer bit separates the full and empty cases.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [7:0]  entry_q [DEPTH];
    logic        pop_en;
    logic        wr_en;

    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_en = pop & ~empty;
    assign wr_en  = push & (~full | pop_en);

    assign head_data = entry_q[rd_ptr_reg[AW-1:0]];

    // Pointer advance; wrap comes from natural overflow of the counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage entries are cleared on reset so the head reads 8'h00 when empty.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [7:0] entry_reg;

            // Capture a byte when this slot is the write target.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    entry_reg <= 8'h00;
                end else if (wr_en && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first, sampling the line at 16x baud in the CPU
// clock domain. Good bytes are queued in a FWFT FIFO with a valid/ready
// handshake; bad stop bits and FIFO overflow are reported as single-cycle
// pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  OS_MID   = 4'(MID_SAMPLE);
    localparam logic [3:0]  OS_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);

    logic        rx_meta_reg;
    logic        rx_sync_reg;
    logic        rx_prev_reg;
    logic        fall_edge;

    logic [15:0] div_cnt_reg;
    logic        tick;

    uart_state_t state_reg;
    uart_state_t state_next;
    logic [3:0]  os_cnt_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  shift_reg;

    logic        sample_mid;
    logic        sample_bit;
    logic        start_entry;
    logic        push;
    logic        frame_err_next;
    logic        overrun_next;

    logic        frame_err_reg;
    logic        overrun_reg;

    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    assign fall_edge  = rx_prev_reg & ~rx_sync_reg;
    assign tick       = (div_cnt_reg == DIV_LAST);
    assign sample_mid = tick && (os_cnt_reg == OS_MID);
    assign sample_bit = tick && (os_cnt_reg == OS_LAST);

    // Two-flop synchronizer plus one delayed copy for falling-edge detect.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= i_rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    // Next-state logic and the per-frame push / error decisions.
    always_comb begin
        state_next     = state_reg;
        start_entry    = 1'b0;
        push           = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (fall_edge) begin
                    state_next  = ST_START;
                    start_entry = 1'b1;
                end
            end
            ST_START: begin
                if (sample_mid) begin
                    // A line back high at mid start bit was only a glitch.
                    state_next = rx_sync_reg ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample_bit && (bit_cnt_reg == BIT_LAST)) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_bit) begin
                    state_next     = ST_IDLE;
                    push           = rx_sync_reg;
                    frame_err_next = ~rx_sync_reg;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FIFO is full and not being drained this cycle: the new byte is lost.
    assign pop          = i_ready & ~fifo_empty;
    assign overrun_next = push & fifo_full & ~pop;

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Tick divider, restarted at the detected start edge for bit alignment.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_cnt_reg <= 16'd0;
        end else if (start_entry || tick) begin
            div_cnt_reg <= 16'd0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 16'd1;
        end
    end

    // Oversample counter: cleared on every state entry, free-wraps in DATA.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            os_cnt_reg <= 4'd0;
        end else if (state_next != state_reg) begin
            os_cnt_reg <= 4'd0;
        end else if (tick) begin
            os_cnt_reg <= os_cnt_reg + 4'd1;
        end
    end

    // Data bit capture: each sample enters at bit 7 so the LSB ends at bit 0.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'h00;
        end else if ((state_reg == ST_START) && (state_next == ST_DATA)) begin
            bit_cnt_reg <= 3'd0;
        end else if ((state_reg == ST_DATA) && sample_bit) begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
        end
    end

    // Error pulses, registered so they appear the clock after the stop sample.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .reset_n   (i_reset_n),
        .push      (push),
        .push_data (shift_reg),
        .pop       (pop),
        .head_data (o_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_valid     = ~fifo_empty;
    assign o_frame_err = frame_err_reg;
    assign o_overrun   = overrun_reg;
    assign o_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, glitch and reset-mid-frame
// sequences, then random frames scored against a byte-queue model.
module tb_uart_rx;

    localparam int BAUD_DIV = 4;
    localparam int DEPTH    = 4;
    localparam int BIT      = 16 * BAUD_DIV;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic       i_rx;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    uart_rx #(
        .BAUD_DIV   (BAUD_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Model: bytes the receiver should currently hold, plus expected pulse totals.
    logic [7:0] model_fifo [$];
    int exp_err = 0;
    int exp_ovr = 0;

    // Observations gathered by the monitor.
    logic [7:0] obs_bytes [$];
    int   obs_err     = 0;
    int   obs_ovr     = 0;
    int   busy_cycles = 0;
    logic err_wide    = 1'b0;
    logic ovr_wide    = 1'b0;
    logic prev_err    = 1'b0;
    logic prev_ovr    = 1'b0;

    // Monitor sampling outputs on the falling clock edge.
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (o_valid && i_ready) obs_bytes.push_back(o_data);
            if (o_frame_err) obs_err <= obs_err + 1;
            if (o_overrun) obs_ovr <= obs_ovr + 1;
            if (o_frame_err && prev_err) err_wide <= 1'b1;
            if (o_overrun && prev_ovr) ovr_wide <= 1'b1;
            if (o_busy) busy_cycles <= busy_cycles + 1;
        end
        prev_err <= o_frame_err;
        prev_ovr <= o_overrun;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Compare every byte the consumer accepted against the model, in order.
    task automatic reconcile();
        logic [7:0] b;
        logic [7:0] e;
        while (obs_bytes.size() > 0) begin
            b = obs_bytes.pop_front();
            checks++;
            if (model_fifo.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte actual=%02h required=none", b);
            end else begin
                e = model_fifo.pop_front();
                if (b !== e) begin
                    errors++;
                    $display("FAIL rx_byte actual=%02h required=%02h", b, e);
                end else begin
                    $display("rx byte %02h ok", b);
                end
            end
        end
    endtask

    // Drive one 8N1 frame after gap_bits idle bit-times; the model decides
    // the byte's fate just before the stop bit when the FIFO level is settled.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int gap_bits, input logic rdy);
        i_ready = rdy;
        i_rx    = 1'b1;
        cyc(gap_bits * BIT);
        i_rx = 1'b0;
        cyc(BIT);
        for (int b = 0; b < 8; b++) begin
            i_rx = d[b];
            cyc(BIT);
        end
        i_rx = stop;
        reconcile();
        if (!stop) begin
            exp_err++;
        end else if (model_fifo.size() < DEPTH) begin
            model_fifo.push_back(d);
        end else begin
            exp_ovr++;
        end
        cyc(BIT);
        if (!stop) begin
            i_rx = 1'b1;
            cyc(BIT);
        end
        reconcile();
        $display("frame data=%02h stop=%0d ready=%0d busy=%0d valid=%0d", d, stop, rdy, o_busy, o_valid);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       rdy;
        int         exp_err;
        int         exp_ovr;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int e0;
        int o0;
        int b0;
        logic [7:0] rd;
        logic [7:0] abort_byte;

        tbl[0] = '{8'hA5, 1'b1, 2, 1'b1, 0, 0};
        tbl[1] = '{8'h3C, 1'b0, 1, 1'b1, 1, 0};
        tbl[2] = '{8'h55, 1'b1, 1, 1'b1, 0, 0};
        tbl[3] = '{8'h01, 1'b1, 1, 1'b0, 0, 0};
        tbl[4] = '{8'h02, 1'b1, 0, 1'b0, 0, 0};
        tbl[5] = '{8'h03, 1'b1, 0, 1'b0, 0, 0};
        tbl[6] = '{8'h04, 1'b1, 0, 1'b0, 0, 0};
        tbl[7] = '{8'h05, 1'b1, 0, 1'b0, 0, 1};
        tbl[8] = '{8'h00, 1'b1, 1, 1'b1, 0, 0};
        tbl[9] = '{8'hFF, 1'b1, 0, 1'b1, 0, 0};

        i_reset_n = 1'b0;
        i_rx      = 1'b1;
        i_ready   = 1'b0;
        cyc(4);
        check("reset_valid", {31'd0, o_valid}, 0);
        check("reset_data", {24'd0, o_data}, 0);
        check("reset_frame_err", {31'd0, o_frame_err}, 0);
        check("reset_overrun", {31'd0, o_overrun}, 0);
        check("reset_busy", {31'd0, o_busy}, 0);
        i_reset_n = 1'b1;
        cyc(5);

        for (int i = 0; i < 10; i++) begin
            e0 = obs_err;
            o0 = obs_ovr;
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].gap, tbl[i].rdy);
            check("busy_after_frame", {31'd0, o_busy}, 0);
            check("frame_err_pulses", obs_err - e0, tbl[i].exp_err);
            check("overrun_pulses", obs_ovr - o0, tbl[i].exp_ovr);
        end
        cyc(4);
        reconcile();
        check("table_fifo_empty", {31'd0, o_valid}, 0);

        // Short low glitch: START entered, then rejected silently.
        b0 = busy_cycles;
        e0 = obs_err;
        i_ready = 1'b1;
        i_rx = 1'b0;
        cyc(16);
        i_rx = 1'b1;
        cyc(BIT);
        check("glitch_busy_seen", {31'd0, (busy_cycles > b0)}, 1);
        check("glitch_busy_low", {31'd0, o_busy}, 0);
        check("glitch_no_err", obs_err - e0, 0);
        check("glitch_no_byte", obs_bytes.size(), 0);
        $display("glitch busy_cycles=%0d", busy_cycles - b0);

        // Reset in the middle of data bit 3 with one byte already buffered.
        send_frame(8'h11, 1'b1, 1, 1'b0);
        abort_byte = 8'h5A;
        i_rx = 1'b0;
        cyc(BIT);
        for (int b = 0; b < 3; b++) begin
            i_rx = abort_byte[b];
            cyc(BIT);
        end
        i_rx = abort_byte[3];
        cyc(BIT / 2);
        i_reset_n = 1'b0;
        cyc(2);
        check("midreset_valid", {31'd0, o_valid}, 0);
        check("midreset_data", {24'd0, o_data}, 0);
        check("midreset_frame_err", {31'd0, o_frame_err}, 0);
        check("midreset_overrun", {31'd0, o_overrun}, 0);
        check("midreset_busy", {31'd0, o_busy}, 0);
        model_fifo.delete();
        obs_bytes.delete();
        i_rx = 1'b1;
        cyc(3);
        i_reset_n = 1'b1;
        cyc(2 * BIT);
        check("post_reset_valid", {31'd0, o_valid}, 0);
        check("post_reset_busy", {31'd0, o_busy}, 0);
        send_frame(8'h96, 1'b1, 1, 1'b1);
        check("post_reset_model_empty", model_fifo.size(), 0);

        // Random frames against the queue model.
        for (int i = 0; i < 16; i++) begin
            rd = 8'($urandom);
            send_frame(rd, ($urandom_range(0, 7) != 0), $urandom_range(0, 2),
                       1'($urandom_range(0, 1)));
            check("rand_frame_err_total", obs_err, exp_err);
            check("rand_overrun_total", obs_ovr, exp_ovr);
            check("rand_busy_after", {31'd0, o_busy}, 0);
        end

        // Drain whatever is left, bounded.
        i_ready = 1'b1;
        for (int k = 0; (k < 20) && (model_fifo.size() > 0); k++) begin
            cyc(1);
            reconcile();
        end
        cyc(2);
        reconcile();
        check("drain_model_empty", model_fifo.size(), 0);
        check("drain_valid_low", {31'd0, o_valid}, 0);
        check("frame_err_single_cycle", {31'd0, err_wide}, 0);
        check("overrun_single_cycle", {31'd0, ovr_wide}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
